// File: rtl/limn2600_pkg.sv
// limn2600_pkg: definitions shared by the instruction-cache refill engine.
//   refill_state_e      - refill FSM states (idle / filling / done pulse / error pulse)
//   LIMN2600_LINE_WORDS - default words per cache line
//   LIMN2600_LINE_OFF_W - byte-offset width of a line built from the default
//   line_off_w()        - byte-offset width for any power-of-two line size
package limn2600_pkg;

    localparam int unsigned LIMN2600_LINE_WORDS = 4;

    // Byte offset within a line: word index bits plus the two byte-in-word bits.
    function automatic int unsigned line_off_w(input int unsigned words);
        return $clog2(words) + 2;
    endfunction

    localparam int unsigned LIMN2600_LINE_OFF_W = line_off_w(LIMN2600_LINE_WORDS);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } refill_state_e;

endpackage

// File: rtl/limn2600_icache_refill_if.sv
// limn2600_icache_refill_if: memory-bus beat interface used by the refill engine.
//   mem_req  - beat request (master -> slave), held until mem_ack
//   mem_addr - word-aligned beat address (master -> slave)
//   mem_ack  - beat complete this cycle (slave -> master), qualified by mem_req
//   mem_data - beat data, valid with mem_ack (slave -> master)
//   mem_err  - beat failed, qualified by mem_ack (slave -> master)
// Modports: master (refill engine), slave (memory / bus model).
interface limn2600_icache_refill_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  mem_req;
    logic [31:0]           mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_err;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data,
        input  mem_err
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data,
        output mem_err
    );
endinterface

// File: rtl/limn2600_refill_beat_ctr.sv
// limn2600_refill_beat_ctr: wrapping word index and beat counter for one line refill.
//   clk, rst  - clock, asynchronous active-high reset
//   load      - start a new line: idx <= start_idx, beat count <= 0
//   start_idx - first word index of the line
//   inc       - one beat accepted: idx advances mod LINE_WORDS, count increments
//   idx       - word index of the current beat
//   last      - current beat is the LINE_WORDS-th of the line
module limn2600_refill_beat_ctr #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [IDX_W-1:0] start_idx,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] cnt_q;

    // LINE_WORDS is a power of two, so the natural IDX_W-bit wrap keeps idx inside the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            idx_q <= start_idx;
            cnt_q <= '0;
        end else if (inc) begin
            idx_q <= idx_q + IDX_W'(1);
            cnt_q <= cnt_q + IDX_W'(1);
        end
    end

    assign idx  = idx_q;
    assign last = (cnt_q == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/limn2600_icache_refill.sv
// limn2600_icache_refill: refill engine for the limn2600 instruction cache.
// On a fetch miss it reads a full line from the memory bus, one beat per word, writes each
// word into the cache write port one cycle after its ack, forwards the missed word to fetch
// and reports completion (fill_done) or a bus error (fill_err).
//   clk, rst               - clock, asynchronous active-high reset
//   miss_valid/addr/ready  - miss request from fetch (accepted when valid && ready)
//   crit_valid/crit_data   - one-cycle pulse carrying the missed word
//   fill_done / fill_err   - one-cycle completion / abort pulses
//   mem (master modport)   - memory bus beat interface
//   cache_we/addr/data     - cache write port
// Build option: LIMN2600_REFILL_CRITICAL_WORD_FIRST_EN - when defined the refill starts at the
// missed word and wraps around the line; otherwise it always starts at word 0.
module limn2600_icache_refill
    import limn2600_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = LIMN2600_LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid,
    input  logic [31:0]           miss_addr,
    output logic                  miss_ready,
    output logic                  crit_valid,
    output logic [DATA_WIDTH-1:0] crit_data,
    output logic                  fill_done,
    output logic                  fill_err,
    limn2600_icache_refill_if.master mem,
    output logic                  cache_we,
    output logic [31:0]           cache_addr,
    output logic [DATA_WIDTH-1:0] cache_data
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W = line_off_w(LINE_WORDS);

    refill_state_e state_q, state_d;

    logic [31-OFF_W:0]     line_q;
    logic [IDX_W-1:0]      crit_idx_q;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      start_idx;
    logic                  last_beat;
    logic                  accept;
    logic                  beat_ok;
    logic                  beat_err;
    logic                  is_crit;

    logic                  cache_we_q;
    logic [31:0]           cache_addr_q;
    logic [DATA_WIDTH-1:0] cache_data_q;
    logic                  crit_valid_q;
    logic [DATA_WIDTH-1:0] crit_data_q;

    // Byte-in-word bits of the miss address carry no information.
    logic unused_miss_addr;
    assign unused_miss_addr = ^miss_addr[1:0];

    assign accept   = (state_q == StIdle) && miss_valid;
    assign beat_ok  = (state_q == StFill) && mem.mem_ack && !mem.mem_err;
    assign beat_err = (state_q == StFill) && mem.mem_ack && mem.mem_err;
    assign is_crit  = (idx == crit_idx_q);

`ifdef LIMN2600_REFILL_CRITICAL_WORD_FIRST_EN
    assign start_idx = miss_addr[OFF_W-1:2];
`else
    assign start_idx = '0;
`endif

    limn2600_refill_beat_ctr #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W)
    ) u_beat_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .start_idx (start_idx),
        .inc       (beat_ok),
        .idx       (idx),
        .last      (last_beat)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (miss_valid) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (beat_err) begin
                    state_d = StErr;
                end else if (beat_ok && last_beat) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; the beat request and address are pure functions of state, so they stay
    // stable for as long as the bus holds off its ack.
    always_comb begin
        miss_ready   = 1'b0;
        mem.mem_req  = 1'b0;
        mem.mem_addr = '0;
        fill_done    = 1'b0;
        fill_err     = 1'b0;
        unique case (state_q)
            StIdle: miss_ready = 1'b1;
            StFill: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = {line_q, idx, 2'b00};
            end
            StDone:  fill_done = 1'b1;
            StErr:   fill_err  = 1'b1;
            default: ;
        endcase
    end

    // Miss latch and registered cache write / critical-word forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q       <= '0;
            crit_idx_q   <= '0;
            cache_we_q   <= 1'b0;
            cache_addr_q <= '0;
            cache_data_q <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            if (accept) begin
                line_q     <= miss_addr[31:OFF_W];
                crit_idx_q <= miss_addr[OFF_W-1:2];
            end
            cache_we_q   <= beat_ok;
            crit_valid_q <= beat_ok && is_crit;
            if (beat_ok) begin
                cache_addr_q <= mem.mem_addr;
                cache_data_q <= mem.mem_data;
            end
            if (beat_ok && is_crit) begin
                crit_data_q <= mem.mem_data;
            end
        end
    end

    assign cache_we   = cache_we_q;
    assign cache_addr = cache_addr_q;
    assign cache_data = cache_data_q;
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;

endmodule

// File: tb/tb_limn2600_icache_refill.sv
// Self-checking bench for limn2600_icache_refill (LINE_WORDS = 4, DATA_WIDTH = 32).
// A memory responder pushes each expected cache write onto a scoreboard queue as it acks a
// beat; writes are popped and compared when the DUT produces them.
module tb_limn2600_icache_refill;

    localparam int unsigned DW = 32;
    localparam int LW = 4;
`ifdef LIMN2600_REFILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_valid;
    logic [31:0]   miss_addr;
    logic          miss_ready;
    logic          crit_valid;
    logic [DW-1:0] crit_data;
    logic          fill_done;
    logic          fill_err;
    logic          cache_we;
    logic [31:0]   cache_addr;
    logic [DW-1:0] cache_data;

    limn2600_icache_refill_if #(.DATA_WIDTH(DW)) mem_if ();

    limn2600_icache_refill #(
        .DATA_WIDTH (DW),
        .LINE_WORDS (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .miss_ready (miss_ready),
        .crit_valid (crit_valid),
        .crit_data  (crit_data),
        .fill_done  (fill_done),
        .fill_err   (fill_err),
        .mem        (mem_if),
        .cache_we   (cache_we),
        .cache_addr (cache_addr),
        .cache_data (cache_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] exp_q[$];

    // Results of the last run_fill: observed (r_*) and model-expected (x_*) values.
    int r_writes, r_done, r_err, r_crit, r_done_cyc, r_err_cyc, r_crit_cyc, r_ready_cyc;
    int x_done_cyc, x_err_cyc, x_crit_cyc, x_crit_cnt;
    logic [31:0] x_crit_data;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return 32'hA0 + 32'(a[3:2]);
    endfunction

    // Memory responder and scoreboard for one miss; called at #1 after a posedge, returns
    // at #1 after the posedge where miss_ready is seen again.
    task automatic run_fill(input logic [31:0] addr, input int max_wait, input int err_beat,
                            input bit hold_miss);
        int cyc, beats, wait_left;
        bit waiting, finished;
        logic [1:0]  m_idx, c_idx;
        logic [31:0] exp_a, prev_a, d;
        logic [63:0] e;
        r_writes = 0; r_done = 0; r_err = 0; r_crit = 0;
        r_done_cyc = -1; r_err_cyc = -1; r_crit_cyc = -1; r_ready_cyc = -1;
        x_done_cyc = -1; x_err_cyc = -1; x_crit_cyc = -1; x_crit_cnt = 0;
        x_crit_data = '0;
        exp_q.delete();
        c_idx = addr[3:2];
        m_idx = CWF ? c_idx : 2'd0;
        prev_a = '0;
        miss_valid = 1'b1;
        miss_addr  = addr;
        n_chk++;
        if (miss_ready !== 1'b1) $display("FAIL accept_ready: got %b expected 1", miss_ready);
        else n_pass++;
        @(posedge clk); #1;
        if (hold_miss) miss_addr = addr ^ 32'h0000_0F00;
        else miss_valid = 1'b0;
        cyc = 1; beats = 0; waiting = 1'b0; finished = 1'b0;
        wait_left = int'($urandom_range(0, max_wait));
        while (!finished && cyc < 200) begin
            if (cache_we === 1'b1) begin
                r_writes++;
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL cache_write: got write %h expected none", cache_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({cache_addr, cache_data} !== e)
                        $display("FAIL cache_write: got %h/%h expected %h/%h",
                                 cache_addr, cache_data, e[63:32], e[31:0]);
                    else n_pass++;
                end
            end
            if (crit_valid === 1'b1) begin
                r_crit++;
                r_crit_cyc = cyc;
                n_chk++;
                if (crit_data !== x_crit_data)
                    $display("FAIL crit_data: got %h expected %h", crit_data, x_crit_data);
                else n_pass++;
            end
            if (fill_done === 1'b1) begin r_done++; r_done_cyc = cyc; end
            if (fill_err === 1'b1) begin r_err++; r_err_cyc = cyc; end
            mem_if.mem_ack  = 1'b0;
            mem_if.mem_err  = 1'b0;
            mem_if.mem_data = '0;
            if (miss_ready === 1'b1) begin
                r_ready_cyc = cyc;
                finished = 1'b1;
            end else if (mem_if.mem_req === 1'b1) begin
                exp_a = {addr[31:4], m_idx, 2'b00};
                n_chk++;
                if (mem_if.mem_addr !== exp_a)
                    $display("FAIL mem_addr: got %h expected %h (cycle %0d)",
                             mem_if.mem_addr, exp_a, cyc);
                else n_pass++;
                if (waiting) begin
                    n_chk++;
                    if (mem_if.mem_addr !== prev_a)
                        $display("FAIL mem_addr_stable: got %h expected %h",
                                 mem_if.mem_addr, prev_a);
                    else n_pass++;
                end
                prev_a  = mem_if.mem_addr;
                waiting = 1'b1;
                if (wait_left == 0) begin
                    beats++;
                    d = mdata(exp_a);
                    mem_if.mem_ack  = 1'b1;
                    mem_if.mem_data = d;
                    if (beats == err_beat) begin
                        mem_if.mem_err = 1'b1;
                        x_err_cyc = cyc + 1;
                    end else begin
                        exp_q.push_back({exp_a, d});
                        if (m_idx == c_idx) begin
                            x_crit_cyc  = cyc + 1;
                            x_crit_data = d;
                            x_crit_cnt++;
                        end
                        if (beats == LW) x_done_cyc = cyc + 1;
                    end
                    m_idx++;
                    waiting = 1'b0;
                    wait_left = int'($urandom_range(0, max_wait));
                end else begin
                    wait_left--;
                end
            end else if (waiting) begin
                n_chk++;
                $display("FAIL mem_req_held: got 0 expected 1 (cycle %0d)", cyc);
                waiting = 1'b0;
            end
            if (!finished) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        miss_valid = 1'b0;
        mem_if.mem_ack = 1'b0;
        mem_if.mem_err = 1'b0;
        if (!finished) begin
            n_chk++;
            $display("FAIL fill_timeout: got no miss_ready expected it within 200 cycles");
        end
        n_chk++;
        if (exp_q.size() != 0)
            $display("FAIL writes_missing: got %0d pending expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        miss_valid = 1'b0; miss_addr = '0;
        mem_if.mem_ack = 1'b0; mem_if.mem_err = 1'b0; mem_if.mem_data = '0;
        #2 rst = 1'b1;
        #2;
        n_chk++;
        if (miss_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", miss_ready);
        else n_pass++;
        n_chk++;
        if ({mem_if.mem_req, mem_if.mem_addr} !== 33'd0)
            $display("FAIL reset_mem: got %b/%h expected 0/0", mem_if.mem_req, mem_if.mem_addr);
        else n_pass++;
        n_chk++;
        if ({cache_we, cache_addr, cache_data, crit_valid, crit_data, fill_done, fill_err} !== '0)
            $display("FAIL reset_outs: got we=%b a=%h d=%h cv=%b cd=%h fd=%b fe=%b expected 0",
                     cache_we, cache_addr, cache_data, crit_valid, crit_data, fill_done,
                     fill_err);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_line(input string name, input int err_expected);
        n_chk++;
        if (r_writes != LW - (err_expected ? 2 : 0))
            $display("FAIL %s_writes: got %0d expected %0d", name, r_writes,
                     LW - (err_expected ? 2 : 0));
        else n_pass++;
        n_chk++;
        if (r_crit != x_crit_cnt || r_crit_cyc != x_crit_cyc)
            $display("FAIL %s_crit: got %0d@%0d expected %0d@%0d", name, r_crit, r_crit_cyc,
                     x_crit_cnt, x_crit_cyc);
        else n_pass++;
        n_chk++;
        if (r_done != (err_expected ? 0 : 1) || r_done_cyc != x_done_cyc)
            $display("FAIL %s_done: got %0d@%0d expected %0d@%0d", name, r_done, r_done_cyc,
                     err_expected ? 0 : 1, x_done_cyc);
        else n_pass++;
        n_chk++;
        if (r_err != err_expected || r_err_cyc != x_err_cyc)
            $display("FAIL %s_err: got %0d@%0d expected %0d@%0d", name, r_err, r_err_cyc,
                     err_expected, x_err_cyc);
        else n_pass++;
        n_chk++;
        if (r_ready_cyc != (err_expected ? x_err_cyc : x_done_cyc) + 1)
            $display("FAIL %s_ready: got cycle %0d expected %0d", name, r_ready_cyc,
                     (err_expected ? x_err_cyc : x_done_cyc) + 1);
        else n_pass++;
    endtask

    task automatic test_basic_fill();
        run_fill(32'h0000_1008, 0, 0, 1'b0);
        check_line("basic", 0);
        n_chk++;
        if (r_done_cyc != 5 || r_ready_cyc != 6)
            $display("FAIL basic_timing: got done@%0d ready@%0d expected done@5 ready@6",
                     r_done_cyc, r_ready_cyc);
        else n_pass++;
    endtask

    task automatic test_crit_order();
        run_fill(32'h0000_100C, 0, 0, 1'b0);
        check_line("crit_order", 0);
    endtask

    task automatic test_wait_states();
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            a = {16'h0000, 4'h5, 6'($urandom_range(0, 63)), 4'(i), 2'b00};
            run_fill(a, 3, 0, 1'b0);
            check_line("wait", 0);
        end
    endtask

    task automatic test_bus_error();
        run_fill(32'h0000_2004, 0, 3, 1'b0);
        check_line("bus_err", 1);
    endtask

    task automatic test_reset_mid_fill();
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_3004;
        @(posedge clk); #1;
        miss_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_if.mem_ack  = 1'b1;
            mem_if.mem_data = 32'h5500_0000 + 32'(b);
            @(posedge clk); #1;
        end
        mem_if.mem_ack = 1'b0;
        n_chk++;
        if (cache_we !== 1'b1 || mem_if.mem_req !== 1'b1)
            $display("FAIL midfill_busy: got we=%b req=%b expected 1/1", cache_we,
                     mem_if.mem_req);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++;
        if (miss_ready !== 1'b1 || mem_if.mem_req !== 1'b0 || mem_if.mem_addr !== '0)
            $display("FAIL midfill_reset_ctl: got rdy=%b req=%b addr=%h expected 1/0/0",
                     miss_ready, mem_if.mem_req, mem_if.mem_addr);
        else n_pass++;
        n_chk++;
        if ({cache_we, cache_addr, cache_data, crit_valid, crit_data, fill_done, fill_err} !== '0)
            $display("FAIL midfill_reset_outs: got we=%b a=%h d=%h cv=%b expected 0",
                     cache_we, cache_addr, cache_data, crit_valid);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_fill(32'h0000_3004, 1, 0, 1'b0);
        check_line("after_reset", 0);
    endtask

    task automatic test_busy_and_spurious();
        mem_if.mem_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            mem_if.mem_ack = 1'b1;
            @(posedge clk); #1;
            n_chk++;
            if (cache_we !== 1'b0 || mem_if.mem_req !== 1'b0 || miss_ready !== 1'b1)
                $display("FAIL spurious_ack: got we=%b req=%b rdy=%b expected 0/0/1",
                         cache_we, mem_if.mem_req, miss_ready);
            else n_pass++;
        end
        mem_if.mem_ack = 1'b0;
        run_fill(32'h0000_4008, 1, 0, 1'b1);
        check_line("busy_miss", 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_chk++;
            if (mem_if.mem_req !== 1'b0 || cache_we !== 1'b0)
                $display("FAIL no_second_accept: got req=%b we=%b expected 0/0",
                         mem_if.mem_req, cache_we);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_crit_order();
        test_wait_states();
        test_bus_error();
        test_reset_mid_fill();
        test_busy_and_spurious();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/limn2600_icache_refill.md
# limn2600_icache_refill

Refill engine feeding the limn2600 instruction cache's write port. When fetch reports a miss, it performs a LINE_WORDS-beat read from the memory bus and writes each returned word into the cache (we/addr_in/data_in). It forwards the missed word to fetch as soon as it arrives and signals completion or bus error. It sits between the fetch stage, the cache, and the memory bus.

## Interface
- DATA_WIDTH, 32, width of a cache word and memory beat
- LINE_WORDS, 4, words per refill line; power of two, >= 2
- clk  in  1  clock, all state on posedge
- rst  in  1  reset, asynchronous, active-high
- miss_valid  in  1  fetch requests refill of miss_addr
- miss_addr  in  32  missed byte address; bits [1:0] ignored
- miss_ready  out  1  engine idle, miss accepted when miss_valid && miss_ready
- crit_valid  out  1  one-cycle pulse, crit_data is the missed word
- crit_data  out  DATA_WIDTH  missed word
- fill_done  out  1  one-cycle pulse, full line written
- fill_err  out  1  one-cycle pulse, refill aborted on bus error
- mem_req  out  1  beat request
- mem_addr  out  32  word-aligned beat address
- mem_ack  in  1  beat complete this cycle (qualified by mem_req)
- mem_data  in  DATA_WIDTH  beat data, valid with mem_ack
- mem_err  in  1  beat failed, qualified by mem_ack
- cache_we  out  1  cache write enable
- cache_addr  out  32  cache write address
- cache_data  out  DATA_WIDTH  cache write data

## Operation
- States: IDLE, FILL, DONE, ERR. miss_ready = (state == IDLE).
- IDLE: on accept, latch base = miss_addr with low log2(LINE_WORDS)+2 bits cleared, and crit_idx = miss_addr word-index bits. Set start index (see Configuration) and beat count 0. Go to FILL.
- FILL: mem_req = 1, mem_addr = base + idx*4. Both are held stable until mem_ack.
- Beat accepted (mem_ack && !mem_err): register the write, so cache_we=1 next cycle with that address and data. If idx == crit_idx, pulse crit_valid with crit_data the same cycle as the write. idx advances mod LINE_WORDS (wraps within the line) and count increments. On the LINE_WORDS-th beat go to DONE, else stay in FILL.
- mem_ack && mem_err: no cache write, no crit_valid; go to ERR. Lines already written stay in the cache; fetch must re-request.
- DONE: fill_done=1 for one cycle, then IDLE. ERR: fill_err=1 for one cycle, then IDLE.
- mem_ack while mem_req=0 is ignored. miss_valid while busy is ignored.
- Reset (async, any state): state IDLE. miss_ready=1. All other outputs 0: mem_req, mem_addr, cache_we, cache_addr, cache_data, crit_valid, crit_data, fill_done, fill_err. An in-flight beat is abandoned, and any partial line already written is not invalidated.

## Timing
- Accept edge E0 → mem_req high from cycle 1.
- Back-to-back acks are allowed: one beat per cycle. After an ack at cycle n, mem_addr shows the next address in cycle n+1.
- cache_we is 1 cycle after the corresponding ack.
- With zero wait states and LINE_WORDS=4: acks in cycles 1–4, cache_we in cycles 2–5, fill_done in cycle 5 (coincident with the last write), miss_ready in cycle 6. Best-case occupancy is LINE_WORDS+2 cycles.
- crit_valid latency is one cycle after the ack of the critical beat.

## Configuration
- LIMN2600_REFILL_CRITICAL_WORD_FIRST_EN defined: start idx = crit_idx, and the fill wraps around the line, so crit_valid always comes one cycle after the first ack.
- Not defined: start idx = 0, ascending order, and crit_valid comes on the beat whose idx equals crit_idx.
- Beat count, fill_done timing and error handling are identical in both cases.

## Structure
- Shared package limn2600_pkg holds:
  - the refill state enum (IDLE/FILL/DONE/ERR)
  - LIMN2600_LINE_WORDS default
  - the line offset-width constant derived from it
- One natural sub-module, limn2600_refill_beat_ctr: the wrapping index and beat counter, with load, increment and last-beat flag.

## Test plan
- Config undefined, miss_addr=0x1008, zero-wait acks with data 0xA0..0xA3 → mem_addr 0x1000,0x1004,0x1008,0x100C; crit_valid with 0xA2 in cycle 4; fill_done in cycle 5.
- Config defined, miss_addr=0x100C → mem_addr 0x100C,0x1000,0x1004,0x1008; crit_valid in cycle 2; cache_addr follows the same order.
- Random ack wait states of 0–3 cycles → mem_req and mem_addr stable while waiting, exactly 4 cache writes, fill_done once.
- mem_err on the 3rd beat → 2 cache writes, no fill_done, fill_err pulse, miss_ready the next cycle.
- rst asserted mid-fill after 2 beats → outputs at reset values immediately, miss_ready=1, a new miss refills normally.
- miss_valid held high during a fill and spurious mem_ack while idle → no second accept, no cache write.
